// File: rtl/gf256_inv_double_sbox_out_stage.sv
// Output stage of the masked double S-box.
// - Maps both 2-share tower-basis inverses into the AES output domain
//   (basis change + affine), one share at a time.
// - Refreshes each S-box with its own fresh mask.
// - Buffers the results in a credit-controlled register FIFO, so the
//   non-stallable upstream pipeline never overruns a stalled consumer.
module gf256_inv_double_sbox_out_stage #(
  parameter int LAT   = 1,
  parameter int DEPTH = 2,
  // Polynomial-basis image of each tower-basis element; entry i is column i.
  // Must match the basis used by the upstream GF16 stages.
  parameter logic [7:0][7:0] TOWER2POLY = {8'h80, 8'h40, 8'hE0, 8'h90,
                                           8'h48, 8'hE4, 8'h32, 8'hB5}
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       launch,
  output logic       launch_ok,
  input  logic [7:0] va0ua0sa0ra0ta0za0ya0xa0,
  input  logic [7:0] va1ua1sa1ra1ta1za1ya1xa1,
  input  logic [7:0] vb0ub0sb0rb0tb0zb0yb0xb0,
  input  logic [7:0] vb1ub1sb1rb1tb1zb1yb1xb1,
  input  logic [7:0] rnd_a,
  input  logic [7:0] rnd_b,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] sa0,
  output logic [7:0] sa1,
  output logic [7:0] sb0,
  output logic [7:0] sb1
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LAT + 1);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_st_e;

  // Linear part of the output map: tower -> polynomial basis, then the AES
  // affine matrix. The 8'h63 constant is added to share 0 only.
  function automatic logic [7:0] l_map(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] a;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (x[i]) p = p ^ TOWER2POLY[i];
    for (int i = 0; i < 8; i++)
      a[i] = p[i] ^ p[3'(i + 4)] ^ p[3'(i + 5)] ^ p[3'(i + 6)] ^ p[3'(i + 7)];
    return a;
  endfunction

  logic [LAT-1:0]            sr_q, sr_d;
  logic [IW-1:0]             infl_q, infl_d;
  logic [OW-1:0]             occ_q, occ_d;
  logic [PW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH-1:0][31:0]    mem_q, mem_d;
  fifo_st_e                  state_q, state_d;

  logic        launch_acc, cap, push, pop;
  logic [7:0]  a0, a1, b0, b1;
  logic [3:0]  credit_used;

  // Share-wise output map and refresh; shares of one S-box never meet.
  always_comb begin
    a0 = l_map(va0ua0sa0ra0ta0za0ya0xa0) ^ 8'h63 ^ rnd_a;
    a1 = l_map(va1ua1sa1ra1ta1za1ya1xa1) ^ rnd_a;
    b0 = l_map(vb0ub0sb0rb0tb0zb0yb0xb0) ^ 8'h63 ^ rnd_b;
    b1 = l_map(vb1ub1sb1rb1tb1zb1yb1xb1) ^ rnd_b;
  end

  // Credit check, launch tracking, FIFO pointer and occupancy updates.
  always_comb begin
    credit_used = 4'(occ_q) + 4'(infl_q);
    launch_ok   = (credit_used < 4'(DEPTH));
    launch_acc  = launch & launch_ok;
    cap         = sr_q[LAT-1];
    push        = cap;
    pop         = out_valid & out_ready;

    sr_d   = LAT'({sr_q, launch_acc});
    infl_d = infl_q + IW'(launch_acc) - IW'(cap);

    wptr_d = wptr_q;
    if (push) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
    rptr_d = rptr_q;
    if (pop)  rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);

    occ_d = occ_q + OW'(push) - OW'(pop);

    mem_d = mem_q;
    if (push) mem_d[wptr_q] = {a0, a1, b0, b1};
  end

  // FIFO fill state follows the next occupancy.
  always_comb begin
    state_d = PARTIAL;
    if (occ_d == '0)            state_d = EMPTY;
    else if (occ_d == OW'(DEPTH)) state_d = FULL;
  end

  // State registers; reset also discards shares of pre-reset launches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q    <= '0;
      infl_q  <= '0;
      occ_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      mem_q   <= '0;
      state_q <= EMPTY;
    end else begin
      sr_q    <= sr_d;
      infl_q  <= infl_d;
      occ_q   <= occ_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      mem_q   <= mem_d;
      state_q <= state_d;
    end
  end

  assign out_valid            = (state_q != EMPTY);
  assign {sa0, sa1, sb0, sb1} = mem_q[rptr_q];

endmodule

// File: tb/tb_gf256_inv_double_sbox_out_stage.sv
// Bench for gf256_inv_double_sbox_out_stage: directed scenarios followed by
// random traffic, checked against a queue-based model of launches and FIFO.
module tb_gf256_inv_double_sbox_out_stage;
  localparam int LAT   = 1;
  localparam int DEPTH = 2;
  localparam logic [7:0] T2P [8] = '{8'hB5, 8'h32, 8'hE4, 8'h48,
                                     8'h90, 8'hE0, 8'h40, 8'h80};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic launch = 1'b0;
  logic launch_ok;
  logic [7:0] ia0 = '0, ia1 = '0, ib0 = '0, ib1 = '0, rnd_a = '0, rnd_b = '0;
  logic out_ready = 1'b0;
  logic out_valid;
  logic [7:0] sa0, sa1, sb0, sb1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dut_acc;
  logic [31:0] fifo[$];
  int pend[$];
  logic [7:0] x0, x1, y0, y1;

  gf256_inv_double_sbox_out_stage #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .launch(launch), .launch_ok(launch_ok),
    .va0ua0sa0ra0ta0za0ya0xa0(ia0), .va1ua1sa1ra1ta1za1ya1xa1(ia1),
    .vb0ub0sb0rb0tb0zb0yb0xb0(ib0), .vb1ub1sb1rb1tb1zb1yb1xb1(ib1),
    .rnd_a(rnd_a), .rnd_b(rnd_b), .out_ready(out_ready), .out_valid(out_valid),
    .sa0(sa0), .sa1(sa1), .sb0(sb0), .sb1(sb1));

  always #5 clk = ~clk;

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  // Reference: expand the tower value over its basis images, then AES affine.
  function automatic logic [7:0] lref(input logic [7:0] x);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (x[i]) p ^= T2P[i];
    return p ^ rotl(p, 1) ^ rotl(p, 2) ^ rotl(p, 3) ^ rotl(p, 4);
  endfunction

  function automatic logic [31:0] entry(input logic [7:0] a0, a1, b0, b1, ra, rb);
    return {lref(a0) ^ 8'h63 ^ ra, lref(a1) ^ ra, lref(b0) ^ 8'h63 ^ rb, lref(b1) ^ rb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, advance the model across the edge, check after.
  task automatic step(input logic l, input logic r, input logic rs,
                      input logic [7:0] a0, a1, b0, b1, ra, rb);
    bit acc, capm, popm;
    launch = l; out_ready = r; rst_n = rs;
    ia0 = a0; ia1 = a1; ib0 = b0; ib1 = b1; rnd_a = ra; rnd_b = rb;
    #1;
    acc  = l && ((DEPTH - fifo.size() - pend.size()) > 0);
    capm = (pend.size() > 0) && (pend[0] == cyc);
    if (l && launch_ok) dut_acc++;
    chk("cap", 32'(dut.cap), 32'(capm));
    if (dut.cap) chk("cap_while_full", 32'(dut.occ_q == DEPTH), 32'd0);
    @(posedge clk);
    if (!rs) begin
      fifo.delete();
      pend.delete();
    end else begin
      popm = (fifo.size() > 0) && r;
      if (popm) void'(fifo.pop_front());
      if (capm) begin
        void'(pend.pop_front());
        fifo.push_back(entry(a0, a1, b0, b1, ra, rb));
      end
      if (acc) pend.push_back(cyc + LAT);
    end
    cyc++;
    #1;
    chk("out_valid", 32'(out_valid), 32'(fifo.size() > 0));
    chk("launch_ok", 32'(launch_ok), 32'((DEPTH - fifo.size() - pend.size()) > 0));
    chk("occ", 32'(dut.occ_q), 32'(fifo.size()));
    chk("infl", 32'(dut.infl_q), 32'(pend.size()));
    if (fifo.size() > 0) chk("head_data", {sa0, sa1, sb0, sb1}, fifo[0]);
  endtask

  task automatic idle(input logic l, input logic r);
    step(l, r, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
         8'($urandom), 8'($urandom));
  endtask

  initial begin
    // Reset state
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_launch_ok", 32'(launch_ok), 1);
    chk("rst_data", {sa0, sa1, sb0, sb1}, 0);

    // Zero inverse: launch, capture next cycle, valid the cycle after
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("zero_not_yet_valid", 32'(out_valid), 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("zero_valid", 32'(out_valid), 1);
    chk("zero_data", {sa0, sa1, sb0, sb1}, 32'h63006300);
    idle(0, 1);

    // Mask invariance for tower value 01 under two share splits
    idle(1, 0);
    step(0, 0, 1, 8'h01, 8'h00, 8'h01, 8'h00, 8'h3C, 8'h3C);
    x0 = sa0; x1 = sa1;
    idle(1, 1);
    step(0, 0, 1, 8'hA5, 8'hA4, 8'hA5, 8'hA4, 8'h3C, 8'h3C);
    y0 = sa0; y1 = sa1;
    chk("mask_unmasked_1", 32'(x0 ^ x1), 32'(lref(8'h01) ^ 8'h63));
    chk("mask_unmasked_2", 32'(y0 ^ y1), 32'(lref(8'h01) ^ 8'h63));
    chk("mask_share1_delta", 32'(x1 ^ y1), 32'(lref(8'hA4)));
    idle(0, 1);

    // Stall and credit: launches every cycle with a stalled consumer;
    // later launches are illegal and must be ignored.
    dut_acc = 0;
    for (int i = 0; i < 6; i++) idle(1, 0);
    chk("stall_accepted", 32'(dut_acc), 2);
    chk("stall_launch_ok", 32'(launch_ok), 0);
    chk("stall_occ", 32'(dut.occ_q), 2);

    // Drain in order; credit comes back one cycle after the first pop
    idle(0, 1);
    chk("drain_credit", 32'(launch_ok), 1);
    idle(0, 1);
    chk("drain_empty", 32'(out_valid), 0);

    // Reset mid-flight: the pre-reset launch must never show up
    idle(1, 0);
    step(0, 0, 0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    for (int i = 0; i < 4; i++) begin
      idle(0, 1);
      chk("rst_flight_valid", 32'(out_valid), 0);
    end
    chk("rst_flight_ok", 32'(launch_ok), 1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0)
        step(1'($urandom), 1'($urandom), 1'b0, 0, 0, 0, 0, 0, 0);
      else
        idle(1'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 8; i++) idle(0, 1);
    chk("final_empty", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
